// File: rtl/fa_bist_pkg.sv
// Shared definitions for the full-adder BIST engine.
//   state_t     : controller state encoding (IDLE / RUN / DONE)
//   NUM_VECTORS : number of exhaustive input vectors {a,b,cin}
//   VEC_W       : width of one stimulus vector
package fa_bist_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NUM_VECTORS = 8;
  localparam int VEC_W       = 3;

endpackage

// File: rtl/fa_golden.sv
// Combinational reference full adder used as the BIST golden model.
// Ports:
//   a, b, cin : vector bits under test
//   s_exp     : expected sum   (a ^ b ^ cin)
//   c_exp     : expected carry (majority of a, b, cin)
module fa_golden (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s_exp,
  output logic c_exp
);

  assign s_exp = a ^ b ^ cin;
  assign c_exp = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/fa_bist.sv
// Built-in self-test engine for a one-bit full adder. Applies the 8 vectors
// {a,b,cin} = 000..111 in ascending order, holds each for SETTLE+1 cycles,
// samples s/c on the last cycle of each vector and compares against the
// golden model.
// Parameters:
//   SETTLE         : extra hold cycles per vector before sampling (0..15)
// Ports:
//   clk, rst       : rising-edge clock, synchronous active-high reset
//   start          : run request, honoured only in IDLE or DONE
//   s, c           : outputs of the adder under test
//   a, b, cin      : registered stimulus to the adder (000 when not running)
//   busy           : high while vectors are being applied
//   done           : one-cycle pulse on run completion
//   pass           : high after a run with zero mismatches, held until start
//   err_count      : number of mismatching vectors in current/last run
//   fail_valid     : at least one mismatch in this run
//   first_fail_vec : {a,b,cin} of the first mismatch
module fa_bist
  import fa_bist_pkg::*;
#(
  parameter int SETTLE = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       s,
  input  logic       c,
  output logic       a,
  output logic       b,
  output logic       cin,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic       fail_valid,
  output logic [2:0] first_fail_vec
);

  localparam logic [3:0]       SETTLE_CNT = 4'(SETTLE);
  localparam logic [VEC_W-1:0] LAST_VEC   = VEC_W'(NUM_VECTORS - 1);

  state_t           state_q, state_d;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic [3:0]       settle_q, settle_d;
  logic [3:0]       err_q, err_d;
  logic             fv_q, fv_d;
  logic [VEC_W-1:0] ffv_q, ffv_d;
  logic             pass_q, pass_d;
  logic             done_q, done_d;

  logic s_exp, c_exp;
  logic sample, last_vec, mismatch;

  fa_golden u_golden (
    .a     (vec_q[2]),
    .b     (vec_q[1]),
    .cin   (vec_q[0]),
    .s_exp (s_exp),
    .c_exp (c_exp)
  );

  assign sample   = (state_q == RUN) && (settle_q == SETTLE_CNT);
  assign last_vec = (vec_q == LAST_VEC);
  // Case-inequality so an X/Z from the adder is scored as a mismatch in
  // simulation; synthesis reduces this to an ordinary compare.
  assign mismatch = ({s, c} !== {s_exp, c_exp});

  // State register and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      vec_q    <= '0;
      settle_q <= '0;
      err_q    <= '0;
      fv_q     <= 1'b0;
      ffv_q    <= '0;
      pass_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      settle_q <= settle_d;
      err_q    <= err_d;
      fv_q     <= fv_d;
      ffv_q    <= ffv_d;
      pass_q   <= pass_d;
      done_q   <= done_d;
    end
  end

  // Next-state logic; start during RUN (including the final sample edge)
  // is deliberately ignored.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: if (start) state_d = RUN;
      RUN:        if (sample && last_vec) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  // Vector/settle counters and result accumulation
  always_comb begin
    vec_d    = vec_q;
    settle_d = settle_q;
    err_d    = err_q;
    fv_d     = fv_q;
    ffv_d    = ffv_q;
    pass_d   = pass_q;
    done_d   = 1'b0;
    if (state_q != RUN) begin
      if (start) begin
        vec_d    = '0;
        settle_d = '0;
        err_d    = '0;
        fv_d     = 1'b0;
        ffv_d    = '0;
        pass_d   = 1'b0;
      end
    end else if (sample) begin
      if (mismatch) begin
        err_d = err_q + 4'd1;
        if (!fv_q) begin
          fv_d  = 1'b1;
          ffv_d = vec_q;
        end
      end
      settle_d = '0;
      if (last_vec) begin
        // vec returns to 000 so the stimulus outputs idle at zero in DONE
        vec_d  = '0;
        done_d = 1'b1;
        pass_d = (err_d == 4'd0);
      end else begin
        vec_d = vec_q + 1'b1;
      end
    end else begin
      settle_d = settle_q + 4'd1;
    end
  end

  // Outputs
  always_comb begin
    busy           = (state_q == RUN);
    a              = vec_q[2];
    b              = vec_q[1];
    cin            = vec_q[0];
    done           = done_q;
    pass           = pass_q;
    err_count      = err_q;
    fail_valid     = fv_q;
    first_fail_vec = ffv_q;
  end

endmodule

// File: tb/tb_fa_bist.sv
// Self-checking bench for fa_bist. Two engines (SETTLE=0 and SETTLE=3) each
// drive a behavioural full adder with a selectable fault. Expected run
// results are pushed to a scoreboard at start and popped when done pulses.
module tb_fa_bist;

  localparam int MODE_OK     = 0;
  localparam int MODE_C_SA0  = 1;
  localparam int MODE_S_INV  = 2;

  typedef struct {
    int         err;
    logic       fv;
    logic [2:0] ffv;
    logic       pass;
  } res_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_r [2];
  logic       s_w [2], c_w [2];
  logic       a_w [2], b_w [2], cin_w [2];
  logic       busy_w [2], done_w [2], pass_w [2], fv_w [2];
  logic [3:0] ec_w [2];
  logic [2:0] ffv_w [2];
  int         mode_r [2];

  res_t sb_q [$];
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  function automatic logic fa_s_f(logic a, logic b, logic cin, int mode);
    logic sv;
    sv = a ^ b ^ cin;
    return (mode == MODE_S_INV) ? ~sv : sv;
  endfunction

  function automatic logic fa_c_f(logic a, logic b, logic cin, int mode);
    if (mode == MODE_C_SA0) return 1'b0;
    return (a & b) | (a & cin) | (b & cin);
  endfunction

  assign s_w[0] = fa_s_f(a_w[0], b_w[0], cin_w[0], mode_r[0]);
  assign c_w[0] = fa_c_f(a_w[0], b_w[0], cin_w[0], mode_r[0]);
  assign s_w[1] = fa_s_f(a_w[1], b_w[1], cin_w[1], mode_r[1]);
  assign c_w[1] = fa_c_f(a_w[1], b_w[1], cin_w[1], mode_r[1]);

  fa_bist #(.SETTLE(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start_r[0]), .s(s_w[0]), .c(c_w[0]),
    .a(a_w[0]), .b(b_w[0]), .cin(cin_w[0]), .busy(busy_w[0]),
    .done(done_w[0]), .pass(pass_w[0]), .err_count(ec_w[0]),
    .fail_valid(fv_w[0]), .first_fail_vec(ffv_w[0])
  );

  fa_bist #(.SETTLE(3)) u_dut1 (
    .clk(clk), .rst(rst), .start(start_r[1]), .s(s_w[1]), .c(c_w[1]),
    .a(a_w[1]), .b(b_w[1]), .cin(cin_w[1]), .busy(busy_w[1]),
    .done(done_w[1]), .pass(pass_w[1]), .err_count(ec_w[1]),
    .fail_valid(fv_w[1]), .first_fail_vec(ffv_w[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input int sel, input string tag);
    chk({tag, "_abc"},  {29'd0, a_w[sel], b_w[sel], cin_w[sel]}, 0);
    chk({tag, "_busy"}, busy_w[sel], 0);
    chk({tag, "_done"}, done_w[sel], 0);
    chk({tag, "_pass"}, pass_w[sel], 0);
    chk({tag, "_ec"},   ec_w[sel],   0);
    chk({tag, "_fv"},   fv_w[sel],   0);
    chk({tag, "_ffv"},  ffv_w[sel],  0);
  endtask

  // One complete run: start_at is the cycle index within the run at which
  // an extra start pulse is driven (-1 for none).
  task automatic run(input int sel, input int mode, input int settle, input int start_at);
    res_t r;
    int   per, total;
    logic [2:0] v3;
    logic ga, gb, gc, gs, gcy;
    per   = settle + 1;
    total = 8 * per;
    mode_r[sel] = mode;
    r = '{err: 0, fv: 1'b0, ffv: 3'd0, pass: 1'b0};
    for (int v = 0; v < 8; v++) begin
      v3  = 3'(v);
      ga  = v3[2]; gb = v3[1]; gc = v3[0];
      gs  = ga ^ gb ^ gc;
      gcy = (ga & gb) | (ga & gc) | (gb & gc);
      if ((fa_s_f(ga, gb, gc, mode) != gs) || (fa_c_f(ga, gb, gc, mode) != gcy)) begin
        if (r.err == 0) r.ffv = v3;
        r.err++;
      end
    end
    r.fv   = (r.err != 0);
    r.pass = (r.err == 0);
    sb_q.push_back(r);

    @(negedge clk); start_r[sel] = 1'b1;
    @(negedge clk); start_r[sel] = 1'b0;
    chk("accept_clr_ec",   ec_w[sel],   0);
    chk("accept_clr_fv",   fv_w[sel],   0);
    chk("accept_clr_pass", pass_w[sel], 0);
    for (int k = 0; k < total; k++) begin
      start_r[sel] = (k == start_at);
      chk("run_busy", busy_w[sel], 1);
      chk("run_vec",  {29'd0, a_w[sel], b_w[sel], cin_w[sel]}, 32'(k / per));
      chk("run_done", done_w[sel], 0);
      @(negedge clk);
    end
    start_r[sel] = 1'b0;
    r = sb_q.pop_front();
    chk("end_done", done_w[sel], 1);
    chk("end_busy", busy_w[sel], 0);
    chk("end_abc",  {29'd0, a_w[sel], b_w[sel], cin_w[sel]}, 0);
    chk("end_ec",   ec_w[sel],   32'(r.err));
    chk("end_fv",   fv_w[sel],   r.fv);
    chk("end_ffv",  ffv_w[sel],  r.ffv);
    chk("end_pass", pass_w[sel], r.pass);
    @(negedge clk);
    chk("hold_done", done_w[sel], 0);
    chk("hold_busy", busy_w[sel], 0);
    chk("hold_pass", pass_w[sel], r.pass);
    chk("hold_ec",   ec_w[sel],   32'(r.err));
  endtask

  initial begin
    start_r[0] = 1'b0; start_r[1] = 1'b0;
    mode_r[0]  = MODE_OK; mode_r[1] = MODE_OK;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_all_zero(0, "rst0");
    chk_all_zero(1, "rst1");
    rst = 1'b0;

    run(0, MODE_OK,    0, -1);
    run(0, MODE_C_SA0, 0, -1);
    run(0, MODE_S_INV, 0, -1);
    run(0, MODE_C_SA0, 0, -1);
    run(0, MODE_OK,    0, -1);
    run(1, MODE_OK,    3, 10);
    run(1, MODE_C_SA0, 3, -1);
    // start coincident with the final sample must be ignored
    run(0, MODE_OK,    0, 7);
    @(negedge clk);
    chk("coincident_start_ignored", busy_w[0], 0);

    // Abort a faulty run at vec=4 with reset
    mode_r[0] = MODE_C_SA0;
    @(negedge clk); start_r[0] = 1'b1;
    @(negedge clk); start_r[0] = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_vec", {29'd0, a_w[0], b_w[0], cin_w[0]}, 4);
    chk("abort_ec",  ec_w[0], 1);
    rst = 1'b1;
    @(negedge clk);
    chk_all_zero(0, "abort");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_idle_busy", busy_w[0], 0);
    chk("abort_idle_done", done_w[0], 0);
    run(0, MODE_OK, 0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
